execute_stage: RTL

Execute stage of the single-cycle Y86-64 processor, directly upstream of the data-memory wrapper. It computes `valE` from decoded operands per `icode`, holds the ZF/SF/OF condition-code register, and evaluates the branch/conditional-move condition `Cnd`. It also keeps a sticky halt flag that freezes the condition codes once the processor has stopped. `valE` feeds the memory stage as address or write-back data; `Cnd` feeds PC selection and conditional-move write-back.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/execute_stage_if.sv | 25 ++
 rtl/execute_stage_alu64.sv | 35 +++
 rtl/execute_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU ops, branch conditions, register ids.
// Used by the fetch, execute and memory-stage blocks.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute operand bundle and execute results; master drives operands, slave returns results.
interface execute_stage_if;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic        Instr_valid;
    logic        imem_error;
    logic [63:0] valE;
    logic        Cnd;
    logic [3:0]  dstE_out;
    logic [2:0]  cc;
    logic        halted;

    modport master (
        output icode, ifun, valA, valB, valC, dstE, Instr_valid, imem_error,
        input  valE, Cnd, dstE_out, cc, halted
    );
    modport slave (
        input  icode, ifun, valA, valB, valC, dstE, Instr_valid, imem_error,
        output valE, Cnd, dstE_out, cc, halted
    );
endinterface

// File: rtl/execute_stage_alu64.sv
// 64-bit combinational ALU computing b op a with zero/sign/overflow flags.
module alu64
    import y86_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  fn,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);
    always_comb begin
        result = b + a;
        of     = (a[63] == b[63]) && (result[63] != a[63]);
        case (fn)
            ALU_SUB: begin
                result = b - a;
                of     = (b[63] != a[63]) && (result[63] != b[63]);
            end
            ALU_AND: begin
                result = b & a;
                of     = 1'b0;
            end
            ALU_XOR: begin
                result = b ^ a;
                of     = 1'b0;
            end
            default: ;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];
endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute: combinational valE/Cnd/dstE_out, registered {ZF,SF,OF} and sticky halt flag.
module execute_stage
    import y86_pkg::*;
#(
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  io
);
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [1:0]  alu_fn;
    logic        alu_en;
    logic [63:0] alu_res;
    logic        alu_zf;
    logic        alu_sf;
    logic        alu_of;
    logic [2:0]  cc_q;
    logic        halted_q;
    logic        cond;
    logic        cnd;
    logic        upd;
    logic        halt_evt;

    always_comb begin
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        alu_fn = ALU_ADD;
        alu_en = 1'b0;
        case (io.icode)
            IRRMOVQ: begin
                alu_a  = io.valA;
                alu_en = 1'b1;
            end
            IIRMOVQ: begin
                alu_a  = io.valC;
                alu_en = 1'b1;
            end
            IRMMOVQ, IMRMOVQ: begin
                alu_a  = io.valC;
                alu_b  = io.valB;
                alu_en = 1'b1;
            end
            IOPQ: begin
                alu_a  = io.valA;
                alu_b  = io.valB;
                alu_fn = io.ifun[1:0];
                alu_en = (io.ifun <= 4'd3);
            end
            ICALL, IPUSHQ: begin
                alu_a  = 64'd8;
                alu_b  = io.valB;
                alu_fn = ALU_SUB;
                alu_en = 1'b1;
            end
            IRET, IPOPQ: begin
                alu_a  = 64'd8;
                alu_b  = io.valB;
                alu_en = 1'b1;
            end
            default: ;
        endcase
    end

    alu64 u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // Conditions read the registered flags, so a branch sees the previous OPq.
    always_comb begin
        cond = 1'b0;
        case (io.ifun)
            C_ALWAYS: cond = 1'b1;
            C_LE:     cond = (cc_q[CC_SF] ^ cc_q[CC_OF]) | cc_q[CC_ZF];
            C_L:      cond = cc_q[CC_SF] ^ cc_q[CC_OF];
            C_E:      cond = cc_q[CC_ZF];
            C_NE:     cond = !cc_q[CC_ZF];
            C_GE:     cond = !(cc_q[CC_SF] ^ cc_q[CC_OF]);
            C_G:      cond = !(cc_q[CC_SF] ^ cc_q[CC_OF]) && !cc_q[CC_ZF];
            default:  cond = 1'b0;
        endcase
    end

    assign cnd      = cond && ((io.icode == IRRMOVQ) || (io.icode == IJXX));
    assign upd      = (io.icode == IOPQ) && (io.ifun <= 4'd3) && io.Instr_valid
                      && !io.imem_error && !halted_q;
    assign halt_evt = (io.icode == IHALT) || !io.Instr_valid || io.imem_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q     <= CC_RESET;
            halted_q <= 1'b0;
        end else begin
            if (upd)
                cc_q <= {alu_zf, alu_sf, alu_of};
            if (halt_evt)
                halted_q <= 1'b1;
        end
    end

    assign io.valE     = alu_en ? alu_res : 64'd0;
    assign io.Cnd      = cnd;
    assign io.dstE_out = ((io.icode == IRRMOVQ) && !cnd) ? RNONE : io.dstE;
    assign io.cc       = cc_q;
    assign io.halted   = halted_q;
endmodule
